// File: rtl/game_pkg.sv
// Shared types and default tuning for the victory controller and its hold timer.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        HOLD       = 2'd1,
        RESTART    = 2'd2,
        MATCH_OVER = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_HOLD_CYCLES = 8;
    localparam int unsigned DEFAULT_WIN_SCORE   = 7;

endpackage

// File: rtl/hold_timer.sv
// Freeze down-counter: loaded with HOLD_CYCLES on HOLD entry, done flags the final HOLD cycle.
module hold_timer
    import game_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam logic [7:0] LOAD_VAL = 8'(HOLD_CYCLES);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // The count reads HOLD_CYCLES in the first HOLD cycle, so 1 marks the last one.
    assign done = (count_q == 8'd1);

endmodule

// File: rtl/victory_ctrl.sv
// Match controller: scores edge hits, freezes the playfield between points, declares the winner.
module victory_ctrl
    import game_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int unsigned WIN_SCORE   = DEFAULT_WIN_SCORE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    input  logic       leftEdgeOn,
    input  logic       rightEdgeOn,
    output logic       lose,
    output logic       roundReset,
    output logic [2:0] leftScore,
    output logic [2:0] rightScore,
    output logic       matchOver,
    output logic       winner
);

    localparam logic [2:0] WIN_VAL = 3'(WIN_SCORE);

    state_e     state_q, state_d;
    logic [2:0] left_q, left_d;
    logic [2:0] right_q, right_d;
    logic       winner_q, winner_d;
    logic       hold_load, hold_done;
    logic       left_pt, right_pt;

    // Simultaneous presses cancel, so a mashing player can never score.
    assign left_pt  = leftEdgeOn  & L & ~R;
    assign right_pt = rightEdgeOn & R & ~L;

    // NOTE: every always_comb output gets a default first, which rules out inferred latches.
    always_comb begin
        state_d   = state_q;
        left_d    = left_q;
        right_d   = right_q;
        winner_d  = winner_q;
        hold_load = 1'b0;
        case (state_q)
            PLAY: begin
                if (left_pt) begin
                    left_d = left_q + 3'd1;
                    if (left_d == WIN_VAL) begin
                        state_d  = MATCH_OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d   = HOLD;
                        hold_load = 1'b1;
                    end
                end else if (right_pt) begin
                    right_d = right_q + 3'd1;
                    if (right_d == WIN_VAL) begin
                        state_d  = MATCH_OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d   = HOLD;
                        hold_load = 1'b1;
                    end
                end
            end
            HOLD:       if (hold_done) state_d = RESTART;
            RESTART:    state_d = PLAY;
            MATCH_OVER: state_d = MATCH_OVER;
            default:    state_d = PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PLAY;
            left_q   <= 3'd0;
            right_q  <= 3'd0;
            winner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            left_q   <= left_d;
            right_q  <= right_d;
            winner_q <= winner_d;
        end
    end

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .reset(reset),
        .load (hold_load),
        .done (hold_done)
    );

    assign lose       = (state_q != PLAY);
    assign roundReset = (state_q == RESTART);
    assign matchOver  = (state_q == MATCH_OVER);
    assign leftScore  = left_q;
    assign rightScore = right_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_victory_ctrl.sv
// Directed bench for victory_ctrl with HOLD_CYCLES=4, WIN_SCORE=3.
module tb_victory_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       L, R, leftEdgeOn, rightEdgeOn;
    logic       lose, roundReset, matchOver, winner;
    logic [2:0] leftScore, rightScore;

    int checks = 0;
    int errors = 0;

    victory_ctrl #(
        .HOLD_CYCLES(4),
        .WIN_SCORE  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .L          (L),
        .R          (R),
        .leftEdgeOn (leftEdgeOn),
        .rightEdgeOn(rightEdgeOn),
        .lose       (lose),
        .roundReset (roundReset),
        .leftScore  (leftScore),
        .rightScore (rightScore),
        .matchOver  (matchOver),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drive inputs from a negedge, let one posedge consume them, return at the next negedge.
    task automatic cycle(input logic rst, input logic l, input logic r,
                         input logic le, input logic re);
        reset = rst; L = l; R = r; leftEdgeOn = le; rightEdgeOn = re;
        @(negedge clk);
        reset = 1'b0; L = 1'b0; R = 1'b0; leftEdgeOn = 1'b0; rightEdgeOn = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_play(input string tag);
        int n = 0;
        while (lose === 1'b1 && n < 20) begin
            idle();
            n++;
        end
        check(tag, int'(lose), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_lose"}, int'(lose), 0);
        check({tag, "_rr"}, int'(roundReset), 0);
        check({tag, "_left"}, int'(leftScore), 0);
        check({tag, "_right"}, int'(rightScore), 0);
        check({tag, "_mo"}, int'(matchOver), 0);
        check({tag, "_win"}, int'(winner), 0);
    endtask

    initial begin
        reset = 1'b1; L = 1'b0; R = 1'b0; leftEdgeOn = 1'b0; rightEdgeOn = 1'b0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all_zero("reset");

        // Left point: score visible at once, freeze for 4 HOLD + 1 RESTART cycles.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("lpt_left", int'(leftScore), 1);
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("lpt_lose_%0d", k), int'(lose), 1);
            check($sformatf("lpt_rr_%0d", k), int'(roundReset), (k == 5) ? 1 : 0);
            idle();
        end
        check("lpt_play_lose", int'(lose), 0);
        check("lpt_play_rr", int'(roundReset), 0);

        // Non-scoring combinations.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("both_left", int'(leftScore), 1);
        check("both_lose", int'(lose), 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("wrong_edge_left", int'(leftScore), 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("no_edge_left", int'(leftScore), 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("r_on_left_edge", int'(rightScore), 0);
        check("nonscore_lose", int'(lose), 0);

        // Right point, then point attempts during HOLD are ignored.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("rpt1_right", int'(rightScore), 1);
        check("rpt1_lose", int'(lose), 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("hold_left", int'(leftScore), 1);
        check("hold_right", int'(rightScore), 1);
        wait_play("hold_wait");

        // Right wins 3-1.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("rpt2_right", int'(rightScore), 2);
        wait_play("rpt2_wait");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("rwin_right", int'(rightScore), 3);
        check("rwin_mo", int'(matchOver), 1);
        check("rwin_winner", int'(winner), 1);
        check("rwin_lose", int'(lose), 1);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, k[0], ~k[0], 1'b1, 1'b1);
            check($sformatf("over_rr_%0d", k), int'(roundReset), 0);
            check($sformatf("over_mo_%0d", k), int'(matchOver), 1);
            check($sformatf("over_right_%0d", k), int'(rightScore), 3);
            check($sformatf("over_left_%0d", k), int'(leftScore), 1);
        end

        // Reset from MATCH_OVER.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all_zero("rst_over");

        // Reset in the second HOLD cycle, then confirm a full-length freeze follows.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("pre_rst_left", int'(leftScore), 1);
        idle();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all_zero("rst_hold");
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("post_rst_lose_%0d", k), int'(lose), 1);
            check($sformatf("post_rst_rr_%0d", k), int'(roundReset), (k == 5) ? 1 : 0);
            idle();
        end
        check("post_rst_play", int'(lose), 0);

        // Left wins 3-0: winner must read 0.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("lwin2_left", int'(leftScore), 2);
        wait_play("lwin2_wait");
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("lwin_left", int'(leftScore), 3);
        check("lwin_mo", int'(matchOver), 1);
        check("lwin_winner", int'(winner), 0);
        check("lwin_rr", int'(roundReset), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/victory_ctrl.md
VICTORY_CTRL -- requirements
Module: victory_ctrl

Interface
REQ-001 Parameter: HOLD_CYCLES, 8, freeze cycles after a point (range 1..255).
REQ-002 Parameter: WIN_SCORE, 7, points that end the match (range 1..7).
REQ-003 Port: clk  input  1  clock; all state changes on posedge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: L  input  1  left-key press pulse, already synchronised, one cycle per press.
REQ-006 Port: R  input  1  right-key press pulse, already synchronised, one cycle per press.
REQ-007 Port: leftEdgeOn  input  1  leftmost playfield light lit.
REQ-008 Port: rightEdgeOn  input  1  rightmost playfield light lit.
REQ-009 Port: lose  output  1  freeze to all playfield lights; high whenever state is not PLAY.
REQ-010 Port: roundReset  output  1  one-cycle pulse that recentres the playfield.
REQ-011 Port: leftScore  output  3  left player points, unsigned.
REQ-012 Port: rightScore  output  3  right player points, unsigned.
REQ-013 Port: matchOver  output  1  high in MATCH_OVER.
REQ-014 Port: winner  output  1  0 = left, 1 = right; valid only while matchOver is high.

Function
REQ-015 FSM states SHALL be PLAY, HOLD, RESTART, MATCH_OVER; all outputs registered or decoded from registered state only.
REQ-016 Left point event SHALL be leftEdgeOn & L & ~R; right point event SHALL be rightEdgeOn & R & ~L; L&R together SHALL never score.
REQ-017 In PLAY, on a point event, the scorer's count SHALL increment at that posedge; lose SHALL be high from the next cycle.
REQ-018 If the incremented score equals WIN_SCORE, next state SHALL be MATCH_OVER and winner SHALL latch the scorer; otherwise next state SHALL be HOLD.
REQ-019 If both point events are true in one cycle, left SHALL take priority (unreachable in normal play).
REQ-020 HOLD SHALL last exactly HOLD_CYCLES cycles, using a down-counter loaded on entry; all inputs ignored.
REQ-021 RESTART SHALL last exactly one cycle with roundReset=1 and lose=1, then return to PLAY.
REQ-022 MATCH_OVER SHALL be terminal until reset: lose=1, matchOver=1, scores and winner held, inputs ignored.
REQ-023 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-024 roundReset SHALL be 0 in every state except RESTART.

Reset
REQ-025 On reset: state PLAY, leftScore=0, rightScore=0, winner=0, matchOver=0, lose=0, roundReset=0, hold counter=0.
REQ-026 Reset SHALL take priority over every event, including mid-HOLD, in RESTART, and in MATCH_OVER.

Structure
REQ-027 State enum and the WIN_SCORE/HOLD_CYCLES defaults SHALL live in shared package game_pkg.
REQ-028 The HOLD down-counter SHALL be sub-module hold_timer (inputs load, clk, reset; output done).

Verification (HOLD_CYCLES=4, WIN_SCORE=3)
REQ-029 Reset, then leftEdgeOn=1, L pulse -> leftScore=1 next cycle; lose=1 for 5 cycles (4 HOLD + 1 RESTART); roundReset high in the 5th only; then PLAY.
REQ-030 leftEdgeOn=1 with L=R=1 -> no score change, lose stays 0.
REQ-031 rightEdgeOn=1 with L pulse -> no score; leftEdgeOn=0 with L pulse -> no score.
REQ-032 Three right points -> rightScore=3, matchOver=1, winner=1, roundReset never pulses after the 3rd point; further pulses change nothing.
REQ-033 Point events issued during HOLD -> ignored, scores unchanged.
REQ-034 Reset asserted in 2nd HOLD cycle and again in MATCH_OVER -> next cycle all outputs 0, state PLAY.
